// File: rtl/control_fsm_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle RV32I-subset controller.
// master = controller side, slave = datapath/memory side.
interface control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_en;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             rf_wr_en;
    logic [1:0]       rf_wr_sel;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_fn;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_en, pc_en, pc_src, rf_wr_en, rf_wr_sel,
               alu_src_b, alu_fn, illegal, bus_err, instret
    );

    modport slave (
        output opcode, funct3, funct7, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_en, pc_en, pc_src, rf_wr_en, rf_wr_sel,
               alu_src_b, alu_fn, illegal, bus_err, instret
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// sticky illegal-opcode and bus-timeout traps.
package alu_fns_pkg;
    typedef logic [3:0] alu_fn_t;
    localparam alu_fn_t ALU_ADD  = 4'd0;
    localparam alu_fn_t ALU_SUB  = 4'd1;
    localparam alu_fn_t ALU_SLL  = 4'd2;
    localparam alu_fn_t ALU_SLT  = 4'd3;
    localparam alu_fn_t ALU_SLTU = 4'd4;
    localparam alu_fn_t ALU_XOR  = 4'd5;
    localparam alu_fn_t ALU_SRL  = 4'd6;
    localparam alu_fn_t ALU_SRA  = 4'd7;
    localparam alu_fn_t ALU_OR   = 4'd8;
    localparam alu_fn_t ALU_AND  = 4'd9;
endpackage

module control_fsm
    import alu_fns_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [TW-1:0]    r_tmo;
    logic             r_illegal;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_instret;

    logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_lui, w_known;
    logic w_mem_req, w_mem_we, w_iord, w_ir_en, w_pc_en, w_rf_wr_en, w_retire;
    logic w_wait, w_tmo_hit, w_taken;
    logic [1:0] w_pc_src, w_rf_wr_sel, w_alu_src_b;
    alu_fn_t    w_alu_fn;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_fn_t alu_dec(input logic alt, input logic [2:0] f3);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // IR only loads in FETCH, so opcode stays valid through EXEC/MEM/WB
    assign w_is_r   = (bus.opcode == OP_R);
    assign w_is_i   = (bus.opcode == OP_I);
    assign w_is_ld  = (bus.opcode == OP_LOAD);
    assign w_is_st  = (bus.opcode == OP_STORE);
    assign w_is_br  = (bus.opcode == OP_BRANCH);
    assign w_is_jal = (bus.opcode == OP_JAL);
    assign w_is_lui = (bus.opcode == OP_LUI);
    assign w_known  = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br | w_is_jal | w_is_lui;
    assign w_taken  = ((bus.funct3 == 3'b000) &  bus.alu_zero)
                    | ((bus.funct3 == 3'b001) & ~bus.alu_zero);

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_iord      = 1'b0;
        w_ir_en     = 1'b0;
        w_pc_en     = 1'b0;
        w_pc_src    = 2'd0;
        w_rf_wr_en  = 1'b0;
        w_rf_wr_sel = 2'd0;
        w_alu_src_b = 2'd0;
        w_alu_fn    = ALU_ADD;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_en = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: w_next = w_known ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_fn = alu_dec(bus.funct7[5], bus.funct3);
                    w_next   = S_WB;
                end else if (w_is_i) begin
                    w_alu_src_b = 2'd1;
                    w_alu_fn    = alu_dec((bus.funct3 == 3'b101) & bus.funct7[5], bus.funct3);
                    w_next      = S_WB;
                end else if (w_is_ld | w_is_st) begin
                    w_alu_src_b = 2'd1;
                    w_next      = S_MEM;
                end else if (w_is_br) begin
                    w_alu_fn = ALU_SUB;
                    w_pc_en  = 1'b1;
                    w_pc_src = w_taken ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_is_jal | w_is_lui) begin
                    w_rf_wr_en  = 1'b1;
                    w_rf_wr_sel = w_is_jal ? 2'd2 : 2'd3;
                    w_pc_en     = 1'b1;
                    w_pc_src    = w_is_jal ? 2'd2 : 2'd0;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_iord      = 1'b1;
                w_mem_we    = w_is_st;
                w_alu_src_b = 2'd1;
                if (bus.mem_ready) begin
                    if (w_is_st) begin
                        w_pc_en  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_wr_en  = 1'b1;
                w_rf_wr_sel = w_is_ld ? 2'd1 : 2'd0;
                w_pc_en     = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
        // a ready in the final wait cycle takes priority over the timeout
        if (w_tmo_hit) w_next = S_TRAP;
    end

    assign w_wait    = w_mem_req & ~bus.mem_ready;
    assign w_tmo_hit = w_wait & (r_tmo == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_tmo     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_tmo   <= (w_wait && (w_next == r_state)) ? r_tmo + 1'b1 : '0;
            if (r_state == S_DECODE && !w_known) r_illegal <= 1'b1;
            if (w_tmo_hit)                       r_bus_err <= 1'b1;
            if (w_retire)                        r_instret <= r_instret + 1'b1;
        end
    end

    // strobes are forced low while reset is held, including a request in flight
    assign bus.mem_req   = rst & w_mem_req;
    assign bus.mem_we    = rst & w_mem_we;
    assign bus.iord      = w_iord;
    assign bus.ir_en     = rst & w_ir_en;
    assign bus.pc_en     = rst & w_pc_en;
    assign bus.pc_src    = w_pc_src;
    assign bus.rf_wr_en  = rst & w_rf_wr_en;
    assign bus.rf_wr_sel = w_rf_wr_sel;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_fn    = w_alu_fn;
    assign bus.illegal   = r_illegal;
    assign bus.bus_err   = r_bus_err;
    assign bus.instret   = r_instret;
endmodule
